// File: rtl/pattern_stream_gen.sv
// Streams a frame of 64-bit words carrying a 7-byte pattern at a programmable byte
// offset, with filler bytes elsewhere. Bytes go out MSB-first within each word.
module pattern_stream_gen #(
   parameter int DATA_WIDTH = 64,
   parameter int PAT_BYTES  = 7,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start_i,
   input  logic [DATA_WIDTH-1:0]   pattern_in,
   input  logic [7:0]              fill_in,
   input  logic [LEN_WIDTH+2:0]    offset_in,
   input  logic [LEN_WIDTH-1:0]    num_words_in,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    data_valid_o,
   input  logic                    data_ready_i,
   output logic                    last_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o
);

   localparam int KW = LEN_WIDTH + 4;   // one spare bit so offset+7 cannot wrap

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t               state;
   logic [55:0]          pattern_q;
   logic [7:0]           fill_q;
   logic [LEN_WIDTH+2:0] offset_q;
   logic [LEN_WIDTH-1:0] num_words_q;
   logic [LEN_WIDTH-1:0] word_idx;
   logic [LEN_WIDTH-1:0] next_idx;
   logic                 start_ok;
   logic                 unused_pat_msb;

   assign unused_pat_msb = ^pattern_in[DATA_WIDTH-1:56];
   assign next_idx       = word_idx + LEN_WIDTH'(1);
   assign start_ok       = (num_words_in != '0) &&
                           ({1'b0, offset_in} + KW'(PAT_BYTES) <= {1'b0, num_words_in, 3'b000});

   // Each lane independently picks pattern byte (k - offset) or the filler byte.
   function automatic logic [63:0] build_word(input logic [LEN_WIDTH-1:0] idx,
                                              input logic [55:0]          pat,
                                              input logic [7:0]           fill,
                                              input logic [LEN_WIDTH+2:0] off);
      logic [KW-1:0] k;
      logic [KW-1:0] rel;
      logic [55:0]   sh;
      build_word = '0;
      for (int l = 0; l < 8; l++) begin
         k   = {1'b0, idx, 3'(l)};
         rel = k - {1'b0, off};
         sh  = pat << {rel[2:0], 3'b000};
         if (k >= {1'b0, off} && rel < KW'(PAT_BYTES))
            build_word[63-8*l -: 8] = sh[55:48];
         else
            build_word[63-8*l -: 8] = fill;
      end
   endfunction

   // NOTE: all state here is sequential, so every assignment is non-blocking to keep
   // reads of old values consistent across the block.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         pattern_q    <= '0;
         fill_q       <= '0;
         offset_q     <= '0;
         num_words_q  <= '0;
         word_idx     <= '0;
         data_out     <= '0;
         data_valid_o <= 1'b0;
         last_o       <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         err_o  <= 1'b0;
         done_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start_i && start_ok) begin
                  pattern_q    <= pattern_in[55:0];
                  fill_q       <= fill_in;
                  offset_q     <= offset_in;
                  num_words_q  <= num_words_in;
                  word_idx     <= '0;
                  data_out     <= build_word('0, pattern_in[55:0], fill_in, offset_in);
                  data_valid_o <= 1'b1;
                  last_o       <= (num_words_in == LEN_WIDTH'(1));
                  busy_o       <= 1'b1;
                  state        <= SEND;
               end else if (start_i) begin
                  err_o <= 1'b1;
               end
            end
            SEND: begin
               if (data_ready_i) begin
                  if (last_o) begin
                     data_valid_o <= 1'b0;
                     last_o       <= 1'b0;
                     done_o       <= 1'b1;
                     state        <= DONE;
                  end else begin
                     word_idx <= next_idx;
                     data_out <= build_word(next_idx, pattern_q, fill_q, offset_q);
                     last_o   <= (next_idx == num_words_q - LEN_WIDTH'(1));
                  end
               end
            end
            DONE: begin
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Self-checking bench for pattern_stream_gen: directed scenarios plus randomized frames
// compared against a byte-level reference model of the frame.
module tb_pattern_stream_gen;

   logic        clock;
   logic        reset;
   logic        start_i;
   logic [63:0] pattern_in;
   logic [7:0]  fill_in;
   logic [10:0] offset_in;
   logic [7:0]  num_words_in;
   logic [63:0] data_out;
   logic        data_valid_o;
   logic        data_ready_i;
   logic        last_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;

   int checks = 0;
   int errors = 0;

   pattern_stream_gen dut (
      .clock        (clock),
      .reset        (reset),
      .start_i      (start_i),
      .pattern_in   (pattern_in),
      .fill_in      (fill_in),
      .offset_in    (offset_in),
      .num_words_in (num_words_in),
      .data_out     (data_out),
      .data_valid_o (data_valid_o),
      .data_ready_i (data_ready_i),
      .last_o       (last_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Frame byte k lives in word k/8 at lane k%8 (lane 0 = MSB); pattern byte j at offset+j.
   function automatic logic [63:0] model_word(input logic [55:0] pat, input logic [7:0] fill,
                                              input int off, input int w);
      logic [7:0]  bytes [8];
      logic [63:0] word;
      for (int b = 0; b < 8; b++) begin
         int k = 8 * w + b;
         if (k >= off && k < off + 7) bytes[b] = pat[55 - 8 * (k - off) -: 8];
         else                         bytes[b] = fill;
      end
      word = '0;
      for (int b = 0; b < 8; b++) word = {word[55:0], bytes[b]};
      return word;
   endfunction

   task automatic setup(input logic [55:0] pat, input logic [7:0] fill, input int off, input int nw);
      pattern_in   = {$urandom_range(0, 255) > 127 ? 8'hFF : 8'h00, pat};
      fill_in      = fill;
      offset_in    = 11'(off);
      num_words_in = 8'(nw);
   endtask

   // Entered at the negedge right after the accepting edge; leaves at a negedge in IDLE.
   task automatic expect_frame(input string name, input logic [55:0] pat, input logic [7:0] fill,
                               input int off, input int nw, input int stall_word,
                               input int stall_cycles, input bit rnd);
      int w      = 0;
      int stalls = 0;
      while (w < nw) begin
         check({name, ".valid"}, 64'(data_valid_o), 64'd1);
         check({name, ".busy"},  64'(busy_o),       64'd1);
         check({name, ".data"},  data_out,          model_word(pat, fill, off, w));
         check({name, ".last"},  64'(last_o),       64'(w == nw - 1));
         if (w == stall_word && stalls < stall_cycles)          data_ready_i = 1'b0;
         else if (rnd && stalls < 4 && $urandom_range(0, 2) == 0) data_ready_i = 1'b0;
         else                                                    data_ready_i = 1'b1;
         if (data_ready_i) begin
            w++;
            stalls = 0;
         end else begin
            stalls++;
         end
         @(negedge clock);
      end
      data_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      check({name, ".done_pulse"}, 64'(done_o),       64'd1);
      check({name, ".done_valid"}, 64'(data_valid_o), 64'd0);
      check({name, ".done_last"},  64'(last_o),       64'd0);
      check({name, ".done_busy"},  64'(busy_o),       64'd1);
      @(negedge clock);
      check({name, ".idle_done"},  64'(done_o),       64'd0);
      check({name, ".idle_busy"},  64'(busy_o),       64'd0);
      check({name, ".idle_valid"}, 64'(data_valid_o), 64'd0);
   endtask

   task automatic run_frame(input string name, input logic [55:0] pat, input logic [7:0] fill,
                            input int off, input int nw, input int stall_word,
                            input int stall_cycles, input bit rnd);
      setup(pat, fill, off, nw);
      start_i = 1'b1;
      @(negedge clock);
      start_i = 1'b0;
      setup($urandom, 8'($urandom), 0, 0);   // inputs may change after accept
      expect_frame(name, pat, fill, off, nw, stall_word, stall_cycles, rnd);
   endtask

   task automatic expect_reject(input string name, input int off, input int nw);
      setup(56'h0123456789ABCD, 8'h5A, off, nw);
      start_i = 1'b1;
      @(negedge clock);
      start_i = 1'b0;
      check({name, ".err"},   64'(err_o),        64'd1);
      check({name, ".valid"}, 64'(data_valid_o), 64'd0);
      check({name, ".busy"},  64'(busy_o),       64'd0);
      @(negedge clock);
      check({name, ".err_clr"}, 64'(err_o),        64'd0);
      check({name, ".valid2"},  64'(data_valid_o), 64'd0);
   endtask

   initial begin
      logic [55:0] pat;
      logic [7:0]  fill;
      int          nw;
      int          off;

      reset        = 1'b0;
      start_i      = 1'b0;
      data_ready_i = 1'b0;
      setup(56'h0, 8'h0, 0, 0);
      #12;
      check("rst.data",  data_out,          64'd0);
      check("rst.valid", 64'(data_valid_o), 64'd0);
      check("rst.last",  64'(last_o),       64'd0);
      check("rst.busy",  64'(busy_o),       64'd0);
      check("rst.done",  64'(done_o),       64'd0);
      check("rst.err",   64'(err_o),        64'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // Single word, pattern at offset 0, and explicit literal expectations.
      check("t1.model", model_word(56'h11223344556677, 8'h00, 0, 0), 64'h1122334455667700);
      run_frame("t1", 56'h11223344556677, 8'h00, 0, 1, -1, 0, 1'b0);

      // Pattern straddling the word boundary.
      check("t2.model0", model_word(56'h11223344556677, 8'hAA, 5, 0), 64'hAAAAAAAAAA112233);
      check("t2.model1", model_word(56'h11223344556677, 8'hAA, 5, 1), 64'h44556677AAAAAAAA);
      run_frame("t2", 56'h11223344556677, 8'hAA, 5, 2, -1, 0, 1'b0);

      // Backpressure for 3 cycles on word 1.
      run_frame("t3", 56'hDEADBEEFC0FFEE, 8'h3C, 9, 3, 1, 3, 1'b0);

      // Rejected starts, including the largest legal-offset boundary next to it.
      expect_reject("t4a", 2, 1);
      expect_reject("t4b", 0, 0);
      expect_reject("t4c", 10, 2);
      run_frame("t4d", 56'hA1B2C3D4E5F607, 8'h99, 9, 2, -1, 0, 1'b0);

      // Asynchronous reset in the middle of word 2 of a 4-word frame.
      pat = 56'h0F1E2D3C4B5A69;
      setup(pat, 8'h77, 20, 4);
      start_i = 1'b1;
      @(negedge clock);
      start_i      = 1'b0;
      data_ready_i = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check("t5.word2", data_out, model_word(pat, 8'h77, 20, 2));
      data_ready_i = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("t5.data",  data_out,          64'd0);
      check("t5.valid", 64'(data_valid_o), 64'd0);
      check("t5.last",  64'(last_o),       64'd0);
      check("t5.busy",  64'(busy_o),       64'd0);
      check("t5.done",  64'(done_o),       64'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      run_frame("t5.new", pat, 8'h77, 20, 4, -1, 0, 1'b0);

      // start_i held high: one frame, one idle gap cycle, then the next frame.
      pat = 56'h13579BDF02468A;
      setup(pat, 8'hC3, 3, 2);
      start_i = 1'b1;
      @(negedge clock);
      expect_frame("t6a", pat, 8'hC3, 3, 2, -1, 0, 1'b0);
      @(negedge clock);
      start_i = 1'b0;
      expect_frame("t6b", pat, 8'hC3, 3, 2, -1, 0, 1'b0);

      // Randomized frames with random backpressure.
      for (int i = 0; i < 12; i++) begin
         pat  = {$urandom, 24'($urandom)};
         fill = 8'($urandom);
         nw   = $urandom_range(1, 6);
         off  = $urandom_range(0, 8 * nw - 7);
         run_frame("rnd", pat, fill, off, nw, -1, 0, 1'b1);
         if ($urandom_range(0, 3) == 0)
            expect_reject("rnd.bad", 8 * nw - 6 + $urandom_range(0, 5), nw);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
